// File: rtl/hilo_mac_unit.sv
// HI/LO register pair with an iterative shift-add multiplier.
// Executes MULT, MULTU, MADD, MSUB (multi-cycle, Busy asserted) and
// MTHI, MTLO (single accept edge, no Busy), and drives HI/LO to the ALU.
module hilo_mac_unit #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BITS_PER_CYC = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        Op,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Hi,
  output logic [DATA_W-1:0] Lo
);

  localparam int unsigned ITER = DATA_W / BITS_PER_CYC;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned PW   = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, CALC, WB} state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MSUB  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP0  = 3'b110,
    OP_NOP1  = 3'b111
  } op_t;

  state_t            state;
  op_t               op_in;
  op_t               op_q;
  logic [PW-1:0]     mcand;
  logic [DATA_W-1:0] mplier;
  logic [PW-1:0]     acc;
  logic              neg_q;
  logic [CW-1:0]     cnt;

  logic              is_signed;
  logic [DATA_W-1:0] mag_a;
  logic [DATA_W-1:0] mag_b;
  logic              sign_in;
  logic [PW-1:0]     acc_next;
  logic [PW-1:0]     prod;
  logic [PW-1:0]     wb_val;

  assign op_in = op_t'(Op);

  // Operand magnitudes and result sign taken at the accept edge
  always_comb begin
    is_signed = (op_in != OP_MULTU);
    mag_a     = (is_signed && A[DATA_W-1]) ? ('0 - A) : A;
    mag_b     = (is_signed && B[DATA_W-1]) ? ('0 - B) : B;
    sign_in   = is_signed && (A[DATA_W-1] ^ B[DATA_W-1]);
  end

  // One step of shift-add: add the multiplicand for each retired multiplier bit
  always_comb begin
    acc_next = acc;
    for (int unsigned j = 0; j < BITS_PER_CYC; j++) begin
      if (mplier[j]) acc_next = acc_next + (mcand << j);
    end
  end

  // Signed product and the value written back to {Hi,Lo}
  always_comb begin
    prod = neg_q ? ('0 - acc) : acc;
    case (op_q)
      OP_MADD: wb_val = {Hi, Lo} + prod;
      OP_MSUB: wb_val = {Hi, Lo} - prod;
      default: wb_val = prod;
    endcase
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      op_q   <= OP_MULT;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      cnt    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            case (op_in)
              OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
                op_q   <= op_in;
                mcand  <= {{DATA_W{1'b0}}, mag_a};
                mplier <= mag_b;
                neg_q  <= sign_in;
                acc    <= '0;
                cnt    <= CW'(ITER - 1);
                Busy   <= 1'b1;
                state  <= CALC;
              end
              OP_MTHI: Hi <= A;
              OP_MTLO: Lo <= A;
              default: ;
            endcase
          end
        end
        CALC: begin
          acc    <= acc_next;
          mcand  <= mcand << BITS_PER_CYC;
          mplier <= mplier >> BITS_PER_CYC;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) state <= WB;
        end
        WB: begin
          {Hi, Lo} <= wb_val;
          Busy     <= 1'b0;
          Done     <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
